// File: rtl/noc_vc_input_unit.sv
// Router input unit: per-VC flit FIFOs with head-flit route computation and
// wormhole state, round-robin VC selection onto a single switch request, and
// one credit returned upstream for every FIFO pop.

// One virtual channel: FIFO, route computation on the head flit, packet FSM.
module noc_vc_input_lane #(
    parameter int          DEPTH         = 4,
    parameter int          FLIT_W        = 64,
    parameter int          X_W           = 4,
    parameter int          Y_W           = 4,
    parameter int          ROUTE_MODE    = 0,
    parameter logic [4:0]  ACTIVATE_PORT = 5'b11111
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic [X_W-1:0]    id_x,
    input  logic [Y_W-1:0]    id_y,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_flit,
    input  logic              pop,
    output logic [FLIT_W-1:0] front,
    output logic [2:0]        route,
    output logic              eligible,
    output logic              disc_req,
    output logic              ovf_ev,
    output logic              proto_ev,
    output logic              route_ev
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0] P_LOCAL = 3'd0, P_NORTH = 3'd1, P_SOUTH = 3'd2,
                           P_EAST  = 3'd3, P_WEST  = 3'd4;

    // DROP swallows a packet whose route points at a disabled port.
    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, push_ok;
    logic [1:0]        ftype;
    logic              is_head, is_last;
    logic [X_W-1:0]    dst_x;
    logic [Y_W-1:0]    dst_y;
    logic [2:0]        x_port, y_port, route_calc, route_q;
    logic              port_ok, route_ld;
    state_t            state_q, state_d;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A full FIFO still takes the write when the same cycle frees a slot.
    assign push_ok = push && (!full || pop);
    assign ovf_ev  = push && full && !pop;
    assign front   = mem[rd_ptr];
    assign ftype   = front[FLIT_W-1 -: 2];
    assign is_head = !ftype[1];                 // 00 single, 01 head
    assign is_last = (ftype[1] == ftype[0]);    // 00 single, 11 tail
    assign dst_x   = front[X_W-1:0];
    assign dst_y   = front[X_W+Y_W-1:X_W];
    assign route   = route_q;
    assign eligible = (state_q == ACTIVE) && !empty;

    // Flit storage; no reset needed since occupancy is tracked by count.
    always_ff @(posedge noc_clk) begin
        if (push_ok) mem[wr_ptr] <= push_flit;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // Dimension-ordered route of the flit at the FIFO front (unsigned compares).
    always_comb begin
        x_port = (dst_x > id_x) ? P_EAST  : P_WEST;
        y_port = (dst_y > id_y) ? P_NORTH : P_SOUTH;
        if (ROUTE_MODE == 0)
            route_calc = (dst_x != id_x) ? x_port : (dst_y != id_y) ? y_port : P_LOCAL;
        else
            route_calc = (dst_y != id_y) ? y_port : (dst_x != id_x) ? x_port : P_LOCAL;
        port_ok = ACTIVATE_PORT[route_calc];
    end

    // Packet state register and latched route.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q <= IDLE;
            route_q <= P_LOCAL;
        end else begin
            state_q <= state_d;
            if (route_ld) route_q <= route_calc;
        end
    end

    // Next-state logic: open a packet on a head, discard stray or unroutable flits.
    always_comb begin
        state_d  = state_q;
        route_ld = 1'b0;
        route_ev = 1'b0;
        proto_ev = 1'b0;
        disc_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (is_head) begin
                        if (port_ok) begin
                            route_ld = 1'b1;
                            state_d  = ACTIVE;
                        end else begin
                            route_ev = 1'b1;
                            state_d  = DROP;
                        end
                    end else begin
                        disc_req = 1'b1;
                        proto_ev = pop;
                    end
                end
            end
            ACTIVE: begin
                if (pop && is_last) state_d = IDLE;
            end
            DROP: begin
                disc_req = !empty;
                if (pop && is_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// Top: VC lanes, round-robin switch request, credit return, sticky errors.
module noc_vc_input_unit #(
    parameter int          CHANNELS      = 4,
    parameter int          DEPTH         = 4,
    parameter int          FLIT_W        = 64,
    parameter int          X_W           = 4,
    parameter int          Y_W           = 4,
    parameter int          ROUTE_MODE    = 0,
    parameter logic [4:0]  ACTIVATE_PORT = 5'b11111,
    localparam int         VC_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              noc_clk,
    input  logic              noc_rst,
    input  logic [X_W-1:0]    id_x,
    input  logic [Y_W-1:0]    id_y,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              credit_valid,
    output logic [VC_W-1:0]   credit_vc,
    output logic              out_valid,
    output logic [2:0]        out_port,
    output logic [VC_W-1:0]   out_vc,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic              err_overflow,
    output logic              err_protocol,
    output logic              err_route
);
    logic [CHANNELS-1:0]             push, pop, elig, disc, ovf_ev, proto_ev, route_ev;
    logic [CHANNELS-1:0][FLIT_W-1:0] front;
    logic [CHANNELS-1:0][2:0]        route;
    logic                            vc_bad, sel_found, disc_found, xfer, pop_any;
    logic [VC_W-1:0]                 sel_vc, disc_vc, pop_vc, rr_q, hold_vc_q;
    logic                            hold_q;

    assign vc_bad = (int'(in_vc) >= CHANNELS);

    // Steer the incoming flit to its VC.
    always_comb begin
        for (int v = 0; v < CHANNELS; v++)
            push[v] = in_valid && !vc_bad && (int'(in_vc) == v);
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_lane
        noc_vc_input_lane #(
            .DEPTH(DEPTH), .FLIT_W(FLIT_W), .X_W(X_W), .Y_W(Y_W),
            .ROUTE_MODE(ROUTE_MODE), .ACTIVATE_PORT(ACTIVATE_PORT)
        ) u_lane (
            .noc_clk(noc_clk), .noc_rst(noc_rst), .id_x(id_x), .id_y(id_y),
            .push(push[v]), .push_flit(in_flit), .pop(pop[v]),
            .front(front[v]), .route(route[v]), .eligible(elig[v]),
            .disc_req(disc[v]), .ovf_ev(ovf_ev[v]), .proto_ev(proto_ev[v]),
            .route_ev(route_ev[v])
        );
    end

    // VC selection (frozen while stalled), discard pick, and the single pop.
    always_comb begin
        sel_found  = 1'b0;
        sel_vc     = '0;
        disc_found = 1'b0;
        disc_vc    = '0;
        pop        = '0;
        pop_vc     = '0;
        if (hold_q) begin
            sel_found = elig[hold_vc_q];
            sel_vc    = hold_vc_q;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!sel_found && elig[(int'(rr_q) + i) % CHANNELS]) begin
                    sel_found = 1'b1;
                    sel_vc    = VC_W'((int'(rr_q) + i) % CHANNELS);
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!disc_found && disc[i]) begin
                disc_found = 1'b1;
                disc_vc    = VC_W'(i);
            end
        end
        xfer = sel_found && out_ready;
        // A discarding VC is never the selected one, so transfer always wins.
        if (xfer) begin
            pop[sel_vc] = 1'b1;
            pop_vc      = sel_vc;
        end else if (disc_found) begin
            pop[disc_vc] = 1'b1;
            pop_vc       = disc_vc;
        end
        pop_any = xfer || disc_found;
    end

    assign out_valid = sel_found;
    assign out_vc    = sel_found ? sel_vc : '0;
    assign out_port  = sel_found ? route[sel_vc] : 3'd0;
    assign out_flit  = sel_found ? front[sel_vc] : '0;

    // Round-robin pointer, stall lock, credit return and sticky error flags.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            rr_q         <= '0;
            hold_q       <= 1'b0;
            hold_vc_q    <= '0;
            credit_valid <= 1'b0;
            credit_vc    <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
            err_route    <= 1'b0;
        end else begin
            hold_q       <= sel_found && !out_ready;
            hold_vc_q    <= sel_vc;
            if (xfer) rr_q <= VC_W'((int'(sel_vc) + 1) % CHANNELS);
            credit_valid <= pop_any;
            credit_vc    <= pop_vc;
            err_overflow <= err_overflow | (|ovf_ev);
            err_protocol <= err_protocol | (|proto_ev) | (in_valid && vc_bad);
            err_route    <= err_route | (|route_ev);
        end
    end
endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Scoreboard bench for noc_vc_input_unit: stimulus pushes expected switch
// outputs, negedge monitors pop and compare on every transfer.
module tb_noc_vc_input_unit;
    logic        noc_clk = 1'b0;
    logic        noc_rst = 1'b1;
    logic [3:0]  id_x = 4'd2, id_y = 4'd2;
    logic        in_valid = 1'b0;
    logic [1:0]  in_vc = 2'd0;
    logic [63:0] in_flit = 64'd0;
    logic        out_ready = 1'b0;
    logic        b_en = 1'b0;

    logic        a_credit_valid, a_out_valid, a_err_ovf, a_err_proto, a_err_route;
    logic [1:0]  a_credit_vc, a_out_vc;
    logic [2:0]  a_out_port;
    logic [63:0] a_out_flit;
    logic        b_credit_valid, b_out_valid, b_err_ovf, b_err_proto, b_err_route;
    logic [1:0]  b_credit_vc, b_out_vc;
    logic [2:0]  b_out_port;
    logic [63:0] b_out_flit;

    typedef struct { logic [1:0] vc; logic [2:0] port; logic [63:0] flit; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   failures = 0;
    int   cred[4] = '{default: 0};

    always #5 noc_clk = ~noc_clk;

    // XY router with NORTH disabled.
    noc_vc_input_unit #(.CHANNELS(4), .DEPTH(4), .FLIT_W(64), .X_W(4), .Y_W(4),
                        .ROUTE_MODE(0), .ACTIVATE_PORT(5'b11101)) dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .id_x(id_x), .id_y(id_y),
        .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .credit_valid(a_credit_valid), .credit_vc(a_credit_vc),
        .out_valid(a_out_valid), .out_port(a_out_port), .out_vc(a_out_vc),
        .out_flit(a_out_flit), .out_ready(out_ready),
        .err_overflow(a_err_ovf), .err_protocol(a_err_proto), .err_route(a_err_route));

    // YX router, all ports enabled, always ready.
    noc_vc_input_unit #(.CHANNELS(4), .DEPTH(4), .FLIT_W(64), .X_W(4), .Y_W(4),
                        .ROUTE_MODE(1), .ACTIVATE_PORT(5'b11111)) dut_yx (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .id_x(id_x), .id_y(id_y),
        .in_valid(in_valid & b_en), .in_vc(in_vc), .in_flit(in_flit),
        .credit_valid(b_credit_valid), .credit_vc(b_credit_vc),
        .out_valid(b_out_valid), .out_port(b_out_port), .out_vc(b_out_vc),
        .out_flit(b_out_flit), .out_ready(1'b1),
        .err_overflow(b_err_ovf), .err_protocol(b_err_proto), .err_route(b_err_route));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input logic [7:0] tag);
        return {t, 46'd0, tag, y, x};
    endfunction

    task automatic push_a(input logic [1:0] vc, input logic [2:0] port, input logic [63:0] f);
        exp_t e;
        e.vc = vc; e.port = port; e.flit = f;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] vc, input logic [2:0] port, input logic [63:0] f);
        exp_t e;
        e.vc = vc; e.port = port; e.flit = f;
        qb.push_back(e);
    endtask

    // One-cycle write on the input link; returns just after the capture edge.
    task automatic send(input logic [1:0] vc, input logic [63:0] f);
        @(posedge noc_clk); #1;
        in_valid = 1'b1; in_vc = vc; in_flit = f;
        @(posedge noc_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge noc_clk); #1;
        out_ready = v;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge noc_clk);
            n++;
        end
        check(name, 64'(qa.size() + qb.size()), 64'd0);
        repeat (3) @(negedge noc_clk);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!a_out_valid && n < 50) begin
            @(negedge noc_clk);
            n++;
        end
        check(name, 64'(a_out_valid), 64'd1);
    endtask

    // Monitor for the XY router: credits and switch transfers.
    always @(negedge noc_clk) begin
        if (!noc_rst) begin
            if (a_credit_valid) cred[a_credit_vc]++;
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) check("a_unexpected_valid", 64'(a_out_valid), 64'd0);
                else begin
                    ea = qa.pop_front();
                    check("a_out_vc", 64'(a_out_vc), 64'(ea.vc));
                    check("a_out_port", 64'(a_out_port), 64'(ea.port));
                    check("a_out_flit", a_out_flit, ea.flit);
                end
            end
        end
    end

    // Monitor for the YX router.
    always @(negedge noc_clk) begin
        if (!noc_rst && b_out_valid) begin
            if (qb.size() == 0) check("b_unexpected_valid", 64'(b_out_valid), 64'd0);
            else begin
                eb = qb.pop_front();
                check("b_out_vc", 64'(b_out_vc), 64'(eb.vc));
                check("b_out_port", 64'(b_out_port), 64'(eb.port));
                check("b_out_flit", b_out_flit, eb.flit);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f, f2;
        int c0, c1, c2;

        // Reset state
        repeat (3) @(negedge noc_clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_flit", a_out_flit, 64'd0);
        check("rst_credit_valid", 64'(a_credit_valid), 64'd0);
        check("rst_errs", 64'({a_err_ovf, a_err_proto, a_err_route}), 64'd0);
        @(posedge noc_clk); #1;
        noc_rst = 1'b0;

        // Single flit to self: LOCAL, visible two cycles after the write
        b_en = 1'b1;
        set_ready(1'b1);
        f = mk(2'b00, 4'd2, 4'd2, 8'h11);
        push_a(2'd0, 3'd0, f);
        push_b(2'd0, 3'd0, f);
        send(2'd0, f);
        @(negedge noc_clk);
        check("lat_t1_valid", 64'(a_out_valid), 64'd0);
        @(negedge noc_clk);
        check("lat_t2_valid", 64'(a_out_valid), 64'd1);
        check("lat_t2_port", 64'(a_out_port), 64'd0);
        @(negedge noc_clk);
        check("credit_valid", 64'(a_credit_valid), 64'd1);
        check("credit_vc", 64'(a_credit_vc), 64'd0);
        drain("drain_local");

        // dst=(5,1) from (2,2): XY -> EAST, YX -> SOUTH
        f = mk(2'b00, 4'd5, 4'd1, 8'h22);
        push_a(2'd0, 3'd3, f);
        push_b(2'd0, 3'd2, f);
        send(2'd0, f);
        drain("drain_xy_yx");
        b_en = 1'b0;

        // Two interleaved 3-flit packets: VC0 EAST, VC1 WEST (0,2)
        c0 = cred[0]; c1 = cred[1];
        push_a(2'd0, 3'd3, mk(2'b01, 4'd5, 4'd1, 8'h30));
        push_a(2'd1, 3'd4, mk(2'b01, 4'd0, 4'd2, 8'h31));
        push_a(2'd0, 3'd3, mk(2'b10, 4'hf, 4'hf, 8'h32));
        push_a(2'd1, 3'd4, mk(2'b10, 4'h0, 4'h0, 8'h33));
        push_a(2'd0, 3'd3, mk(2'b11, 4'h1, 4'h7, 8'h34));
        push_a(2'd1, 3'd4, mk(2'b11, 4'h9, 4'h3, 8'h35));
        send(2'd0, mk(2'b01, 4'd5, 4'd1, 8'h30));
        send(2'd1, mk(2'b01, 4'd0, 4'd2, 8'h31));
        send(2'd0, mk(2'b10, 4'hf, 4'hf, 8'h32));
        send(2'd1, mk(2'b10, 4'h0, 4'h0, 8'h33));
        send(2'd0, mk(2'b11, 4'h1, 4'h7, 8'h34));
        send(2'd1, mk(2'b11, 4'h9, 4'h3, 8'h35));
        drain("drain_interleave");
        check("credits_vc0", 64'(cred[0] - c0), 64'd3);
        check("credits_vc1", 64'(cred[1] - c1), 64'd3);

        // Stall: VC1 held while VC0 becomes eligible ahead of the pointer
        set_ready(1'b0);
        f  = mk(2'b00, 4'd2, 4'd0, 8'h41);
        f2 = mk(2'b00, 4'd2, 4'd2, 8'h42);
        push_a(2'd1, 3'd2, f);
        push_a(2'd0, 3'd0, f2);
        send(2'd1, f);
        wait_valid("hold_wait");
        send(2'd0, f2);
        for (int k = 0; k < 5; k++) begin
            @(negedge noc_clk);
            check("hold_vc", 64'(a_out_vc), 64'd1);
            check("hold_port", 64'(a_out_port), 64'd2);
            check("hold_flit", a_out_flit, f);
        end
        set_ready(1'b1);
        drain("drain_hold");

        // Overflow: five writes to VC2 with the switch stalled
        set_ready(1'b0);
        c2 = cred[2];
        f = mk(2'b01, 4'd1, 4'd2, 8'h50);
        push_a(2'd2, 3'd4, f);
        send(2'd2, f);
        for (int k = 1; k <= 4; k++) begin
            f = mk(2'b10, 4'd0, 4'd0, 8'(8'h50 + k));
            if (k < 4) push_a(2'd2, 3'd4, f);
            send(2'd2, f);
        end
        @(negedge noc_clk);
        check("err_overflow", 64'(a_err_ovf), 64'd1);
        check("no_err_protocol", 64'(a_err_proto), 64'd0);
        set_ready(1'b1);
        drain("drain_overflow");
        check("credits_vc2", 64'(cred[2] - c2), 64'd4);
        f = mk(2'b11, 4'd0, 4'd0, 8'h55);
        push_a(2'd2, 3'd4, f);
        send(2'd2, f);
        drain("drain_vc2_tail");

        // Body flit on idle VC1
        c1 = cred[1];
        send(2'd1, mk(2'b10, 4'd0, 4'd0, 8'h60));
        repeat (4) @(negedge noc_clk);
        check("err_protocol", 64'(a_err_proto), 64'd1);
        check("credits_stray", 64'(cred[1] - c1), 64'd1);
        check("no_err_route", 64'(a_err_route), 64'd0);

        // Packet routed NORTH (disabled): head and tail discarded
        c0 = cred[0];
        send(2'd0, mk(2'b01, 4'd2, 4'd5, 8'h61));
        send(2'd0, mk(2'b11, 4'd0, 4'd0, 8'h62));
        repeat (4) @(negedge noc_clk);
        check("err_route", 64'(a_err_route), 64'd1);
        check("credits_dropped", 64'(cred[0] - c0), 64'd2);
        f = mk(2'b00, 4'd2, 4'd2, 8'h63);
        push_a(2'd0, 3'd0, f);
        send(2'd0, f);
        drain("drain_after_drop");

        // Reset mid-packet
        set_ready(1'b0);
        send(2'd3, mk(2'b01, 4'd5, 4'd2, 8'h70));
        wait_valid("rst_wait");
        @(posedge noc_clk); #1;
        noc_rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(a_out_valid), 64'd0);
        check("midrst_out_flit", a_out_flit, 64'd0);
        check("midrst_out_port", 64'(a_out_port), 64'd0);
        check("midrst_errs", 64'({a_err_ovf, a_err_proto, a_err_route}), 64'd0);
        repeat (2) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
        set_ready(1'b1);
        f = mk(2'b00, 4'd5, 4'd1, 8'h71);
        push_a(2'd0, 3'd3, f);
        send(2'd0, f);
        drain("drain_after_rst");
        check("post_rst_err_route", 64'(a_err_route), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
